irq_sync_ctrl: RTL and testbench
================================

IRQ_SYNC_CTRL -- requirements
Module: irq_sync_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 8: number of interrupt channels, legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per channel, legal range 2..4.
REQ-003 Port clk, input, 1: single clock; all state is on the rising edge.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port irq_in, input, NUM_IRQ: asynchronous interrupt sources from other clock domains; bit 0 has highest priority.
REQ-006 Port irq_mask, input, NUM_IRQ: 1 = channel masked; clk domain.
REQ-007 Port irq_req, output, 1: interrupt request to the CPU.
REQ-008 Port irq_id, output, $clog2(NUM_IRQ) (min 1): index of the requested channel.
REQ-009 Port irq_ack, input, 1: one-cycle CPU acknowledge of irq_id.
REQ-010 Port irq_pending, output, NUM_IRQ: pending vector, before masking.
REQ-011 Port irq_overrun, output, NUM_IRQ: one-cycle pulse when an edge arrives on an already-pending channel.

Function
REQ-012 Each irq_in bit shall pass through a SYNC_STAGES flop chain; the last stage feeds a 1-flop history register for edge detection.
REQ-013 A synchronised 0->1 transition shall set pending[i] on the following edge; total latency from first sampling edge to pending set is exactly SYNC_STAGES+1 cycles.
REQ-014 The FSM shall have the states IDLE, REQ and GAP.
REQ-015 IDLE: if (pending & ~irq_mask) != 0, latch the lowest set index into irq_id, assert irq_req and go to REQ on the next edge.
REQ-016 REQ: irq_req=1; irq_id shall stay stable regardless of new or higher-priority arrivals or mask changes; irq_ack goes to GAP.
REQ-017 On irq_ack in REQ, pending[irq_id] shall clear on the same edge unless a new edge for that channel arrives in that same cycle, in which case it stays set (set wins).
REQ-018 GAP: irq_req=0 for exactly one cycle, then go to IDLE; the earliest re-request is one cycle later.
REQ-019 irq_ack outside REQ shall be ignored.
REQ-020 irq_overrun[i] shall pulse for one cycle when an edge is detected while pending[i]=1 and is not simultaneously being cleared; pending stays 1.
REQ-021 Masked channels shall still set pending; unmasking shall make them eligible in the next IDLE evaluation.

Reset
REQ-022 reset_n=0 shall asynchronously clear sync chains, history, pending, irq_overrun, irq_req and irq_id, and force the FSM to IDLE.
REQ-023 Reset asserted mid-request shall drop irq_req immediately; after release, an irq_in that was already high shall not produce an edge until it falls and rises again.

Configuration
REQ-024 With IRQ_LEVEL_MODE_EN defined:
- add input irq_level, NUM_IRQ wide.
- Channels with irq_level=1 shall have pending equal to the synchronised level.
- irq_ack does not clear a level-mode channel and irq_overrun never pulses for it.
- A level-mode channel that is still high re-requests after GAP.
REQ-025 Without IRQ_LEVEL_MODE_EN, the irq_level port shall be absent and all channels shall be rising-edge only.

Structure
REQ-026 Package fpgc_irq_pkg shall hold the FSM state typedef (IDLE/REQ/GAP), MAX_IRQ=32 and MAX_SYNC_STAGES=4.
REQ-027 Sub-module irq_sync (parametrised width and stage count, async active-low clear) shall implement the synchroniser chains.
REQ-028 The priority encoder, pending logic and FSM shall stay in irq_sync_ctrl.

Verification
REQ-029 Single edge: NUM_IRQ=8, SYNC_STAGES=2, irq_in[3] rises -> irq_req=1 with irq_id=3 on cycle 4; ack -> irq_req=0 for one cycle; pending[3]=0.
REQ-030 Priority: irq_in[5] and irq_in[1] rise together -> id 1 served first; after ack + GAP -> id 5 requested; irq_in[0] rising during REQ(id 5) does not change irq_id.
REQ-031 Mask: irq_mask[2]=1, edge on 2 -> pending[2]=1, no request; clear the mask -> request with id 2 within 1 cycle.
REQ-032 Overrun and set-wins: second edge on pending channel 4 -> irq_overrun[4] pulses once; a new edge in the ack cycle of id 4 -> pending[4] stays 1 and it re-requests after GAP.
REQ-033 Reset mid-REQ: reset_n low during REQ -> irq_req=0 asynchronously and all outputs 0; irq_in held high through release -> no request.
REQ-034 IRQ_LEVEL_MODE_EN: level channel 6 held high across 3 acks -> 3 requests separated by 1-cycle gaps; drop it -> no further request.

Source files
------------

// File: rtl/fpgc_irq_pkg.sv
// -----------------------------------------------------------------------------
// fpgc_irq_pkg
// Purpose : shared definitions for the interrupt synchroniser / controller.
//           Holds the controller FSM state type, the legal size limits and a
//           helper that folds an out-of-range stage count into the legal range.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package fpgc_irq_pkg;

   localparam int MAX_IRQ         = 32;
   localparam int MAX_SYNC_STAGES = 4;

   // Post-reset warm-up counter must reach MAX_SYNC_STAGES+1.
   localparam int WARM_W = $clog2(MAX_SYNC_STAGES + 2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2
   } irq_state_e;

   // Keep the synchroniser depth inside 2..MAX_SYNC_STAGES.
   function automatic int clamp_stages(input int s);
      if (s < 2) begin
         return 2;
      end else if (s > MAX_SYNC_STAGES) begin
         return MAX_SYNC_STAGES;
      end
      return s;
   endfunction

endpackage

// File: rtl/irq_sync.sv
// -----------------------------------------------------------------------------
// irq_sync
// Purpose : multi-flop synchroniser, one independent chain per bit.
// Params  : WIDTH  - number of bits synchronised
//           STAGES - flops per chain (2..MAX_SYNC_STAGES)
// Ports   : clk   in  - destination clock
//           clr_n in  - asynchronous active-low clear of every stage
//           d     in  - asynchronous inputs [WIDTH-1:0]
//           q     out - synchronised outputs [WIDTH-1:0] (last stage)
// -----------------------------------------------------------------------------
module irq_sync
   import fpgc_irq_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   localparam int N_STG = clamp_stages(STAGES);

   // Element 0 is the first sampling flop, element N_STG-1 the output.
   logic [N_STG-1:0][WIDTH-1:0] stage_q;
   logic [N_STG-1:0][WIDTH-1:0] stage_d;

   always_comb begin
      stage_d = {stage_q[N_STG-2:0], d};
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign q = stage_q[N_STG-1];

endmodule

// File: rtl/irq_sync_ctrl.sv
// -----------------------------------------------------------------------------
// irq_sync_ctrl
// Purpose : collects asynchronous interrupt sources, synchronises them,
//           latches rising edges into a pending vector and presents the
//           lowest-numbered unmasked pending channel to the CPU through a
//           req/ack handshake (IDLE -> REQ -> GAP -> IDLE).
// Params  : NUM_IRQ (1..32), SYNC_STAGES (2..4)
// Ports   : clk          in  - clock, all state on rising edge
//           reset_n      in  - asynchronous active-low reset
//           irq_in       in  - asynchronous interrupt sources, bit 0 highest
//           irq_mask     in  - 1 = channel not eligible for request
//           irq_level    in  - (IRQ_LEVEL_MODE_EN only) 1 = level channel
//           irq_ack      in  - one-cycle acknowledge of irq_id
//           irq_req      out - interrupt request
//           irq_id       out - requested channel index
//           irq_pending  out - pending vector before masking
//           irq_overrun  out - one-cycle pulse, edge on already-pending chan
// Build   : define IRQ_LEVEL_MODE_EN to add per-channel level mode.
// -----------------------------------------------------------------------------
module irq_sync_ctrl
   import fpgc_irq_pkg::*;
#(
   parameter  int NUM_IRQ     = 8,
   parameter  int SYNC_STAGES = 2,
   localparam int ID_W        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic [NUM_IRQ-1:0] irq_mask,
`ifdef IRQ_LEVEL_MODE_EN
   input  logic [NUM_IRQ-1:0] irq_level,
`endif
   input  logic               irq_ack,
   output logic               irq_req,
   output logic [ID_W-1:0]    irq_id,
   output logic [NUM_IRQ-1:0] irq_pending,
   output logic [NUM_IRQ-1:0] irq_overrun
);

   localparam int               N_STG     = clamp_stages(SYNC_STAGES);
   localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(N_STG + 1);

   logic [NUM_IRQ-1:0] sync_lvl;
   logic [NUM_IRQ-1:0] level_sel;
   logic [NUM_IRQ-1:0] hist_q, hist_d;
   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic [NUM_IRQ-1:0] overrun_q, overrun_d;
   logic [NUM_IRQ-1:0] rise, clr, eligible;
   logic [WARM_W-1:0]  warm_q, warm_d;
   logic [ID_W-1:0]    low_id;

   irq_state_e         state_q;
   logic               req_q;
   logic [ID_W-1:0]    id_q;

`ifdef IRQ_LEVEL_MODE_EN
   assign level_sel = irq_level;
`else
   assign level_sel = '0;
`endif

   irq_sync #(
      .WIDTH  (NUM_IRQ),
      .STAGES (N_STG)
   ) u_sync (
      .clk   (clk),
      .clr_n (reset_n),
      .d     (irq_in),
      .q     (sync_lvl)
   );

   always_comb begin
      // Reset empties the chains, so an input already high at release would
      // look like a fresh 0->1. Edges are ignored until the chain and the
      // history flop both hold post-release samples.
      warm_d = (warm_q == WARM_DONE) ? warm_q : warm_q + 1'b1;
      hist_d = sync_lvl;
      rise   = (warm_q == WARM_DONE) ? (sync_lvl & ~hist_q & ~level_sel) : '0;

      clr = '0;
      if (state_q == REQ && irq_ack) begin
         clr[id_q] = 1'b1;
      end
      clr = clr & ~level_sel;

      // A same-cycle edge beats the ack clear and is not an overrun.
      overrun_d = rise & pending_q & ~clr;
      pending_d = (((pending_q & ~clr) | rise) & ~level_sel) |
                  (sync_lvl & level_sel);

      eligible = pending_q & ~irq_mask;
      low_id   = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            low_id = ID_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         warm_q    <= '0;
         hist_q    <= '0;
         pending_q <= '0;
         overrun_q <= '0;
      end else begin
         warm_q    <= warm_d;
         hist_q    <= hist_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

   // irq_id only loads on the IDLE->REQ transition, so it holds through REQ
   // and GAP whatever happens to pending or the mask.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         id_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|eligible) begin
                  id_q    <= low_id;
                  req_q   <= 1'b1;
                  state_q <= REQ;
               end
            end
            REQ: begin
               if (irq_ack) begin
                  req_q   <= 1'b0;
                  state_q <= GAP;
               end
            end
            GAP: begin
               state_q <= IDLE;
            end
            default: begin
               req_q   <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign irq_req     = req_q;
   assign irq_id      = id_q;
   assign irq_pending = pending_q;
   assign irq_overrun = overrun_q;

endmodule

// File: tb/tb_irq_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_sync_ctrl
// Directed scenarios against irq_sync_ctrl (NUM_IRQ=8, SYNC_STAGES=2) with a
// cycle model derived from the input sample history, plus literal checks.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_irq_sync_ctrl;

   localparam int N   = 8;
   localparam int S   = 2;
   localparam int IDW = 3;

   logic           clk      = 1'b0;
   logic           reset_n  = 1'b1;
   logic [N-1:0]   irq_in   = '0;
   logic [N-1:0]   irq_mask = '0;
   logic           irq_ack  = 1'b0;
`ifdef IRQ_LEVEL_MODE_EN
   logic [N-1:0]   irq_level = '0;
`endif
   logic           irq_req;
   logic [IDW-1:0] irq_id;
   logic [N-1:0]   irq_pending;
   logic [N-1:0]   irq_overrun;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   irq_sync_ctrl #(
      .NUM_IRQ     (N),
      .SYNC_STAGES (S)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .irq_in      (irq_in),
      .irq_mask    (irq_mask),
`ifdef IRQ_LEVEL_MODE_EN
      .irq_level   (irq_level),
`endif
      .irq_ack     (irq_ack),
      .irq_req     (irq_req),
      .irq_id      (irq_id),
      .irq_pending (irq_pending),
      .irq_overrun (irq_overrun)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   // Edge n (1-based since reset release) sees samp[n]; the synchronised view
   // at edge n is the sample taken S edges earlier. A rise counts only between
   // two post-release samples.
   logic [N-1:0]   samp [8];
   int             n;
   logic [N-1:0]   m_pend, m_ovr, m_rise, m_clr, m_lvl, m_lmask, m_elig;
   logic           m_req;
   logic [IDW-1:0] m_id;
   int             m_st;   // 0 idle, 1 requesting, 2 gap

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         n = 0; m_pend = '0; m_ovr = '0; m_req = 1'b0; m_id = '0; m_st = 0;
      end else begin
         n = n + 1;
         samp[n % 8] = irq_in;
`ifdef IRQ_LEVEL_MODE_EN
         m_lmask = irq_level;
`else
         m_lmask = '0;
`endif
         m_rise = '0;
         m_lvl  = '0;
         if (n - S >= 1) m_lvl = samp[(n - S) % 8];
         if (n - S - 1 >= 1) m_rise = samp[(n - S) % 8] & ~samp[(n - S - 1) % 8];
         m_rise = m_rise & ~m_lmask;
         m_clr = '0;
         if (m_st == 1 && irq_ack) m_clr[m_id] = 1'b1;
         m_clr  = m_clr & ~m_lmask;
         m_elig = m_pend & ~irq_mask;
         m_ovr  = m_rise & m_pend & ~m_clr;
         case (m_st)
            0: if (m_elig != '0) begin
                  for (int i = N - 1; i >= 0; i--) if (m_elig[i]) m_id = IDW'(i);
                  m_req = 1'b1;
                  m_st  = 1;
               end
            1: if (irq_ack) begin m_req = 1'b0; m_st = 2; end
            default: m_st = 0;
         endcase
         m_pend = (((m_pend & ~m_clr) | m_rise) & ~m_lmask) | (m_lvl & m_lmask);
      end
   end

   always @(negedge clk) begin
      check("model_req",     32'(irq_req),     32'(m_req));
      check("model_id",      32'(irq_id),      32'(m_id));
      check("model_pending", 32'(irq_pending), 32'(m_pend));
      check("model_overrun", 32'(irq_overrun), 32'(m_ovr));
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic wait_req(input string name, input int maxc);
      int c = 0;
      while (!irq_req && c < maxc) begin
         @(negedge clk);
         c++;
      end
      check(name, 32'(irq_req), 32'd1);
   endtask

   task automatic do_ack();
      $display("txn: ack id=%0d at %0t", irq_id, $time);
      irq_ack = 1'b1;
      @(negedge clk);
      irq_ack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected end by 200000");
      $fatal(1);
   end

   initial begin
      int ovr_cnt;

      // ---- reset state ----
      #1 reset_n = 1'b0;
      #2;
      check("rst_req",     32'(irq_req),     32'd0);
      check("rst_id",      32'(irq_id),      32'd0);
      check("rst_pending", 32'(irq_pending), 32'd0);
      check("rst_overrun", 32'(irq_overrun), 32'd0);
      tick(2);
      #2 reset_n = 1'b1;
      tick(5);

      // ---- single edge on channel 3 ----
      $display("txn: single edge ch3");
      irq_in[3] = 1'b1;
      tick(3);
      check("se_pending_c3", 32'(irq_pending), 32'h08);
      check("se_req_c3",     32'(irq_req),     32'd0);
      tick(1);
      check("se_req_c4", 32'(irq_req), 32'd1);
      check("se_id_c4",  32'(irq_id),  32'd3);
      do_ack();
      check("se_gap_req", 32'(irq_req),     32'd0);
      check("se_cleared", 32'(irq_pending), 32'h00);
      tick(1);
      check("se_idle_req", 32'(irq_req), 32'd0);
      irq_in[3] = 1'b0;
      tick(4);

      // ---- priority ----
      $display("txn: priority ch1+ch5");
      irq_in[5] = 1'b1; irq_in[1] = 1'b1;
      wait_req("pri_wait1", 10);
      check("pri_first_id", 32'(irq_id), 32'd1);
      do_ack();
      wait_req("pri_wait5", 6);
      check("pri_second_id", 32'(irq_id), 32'd5);
      irq_in[0] = 1'b1;
      tick(6);
      check("pri_hold_req", 32'(irq_req), 32'd1);
      check("pri_hold_id",  32'(irq_id),  32'd5);
      do_ack();
      wait_req("pri_wait0", 6);
      check("pri_third_id", 32'(irq_id), 32'd0);
      do_ack();
      irq_in = '0;
      tick(4);

      // ---- mask ----
      $display("txn: masked ch2");
      irq_mask[2] = 1'b1; irq_in[2] = 1'b1;
      tick(6);
      check("mask_pending", 32'(irq_pending), 32'h04);
      check("mask_noreq",   32'(irq_req),     32'd0);
      irq_mask[2] = 1'b0;
      tick(1);
      check("unmask_req", 32'(irq_req), 32'd1);
      check("unmask_id",  32'(irq_id),  32'd2);
      do_ack();
      irq_in[2] = 1'b0;
      tick(4);

      // ---- overrun and set-wins on channel 4 ----
      $display("txn: overrun ch4");
      irq_in[4] = 1'b1;
      wait_req("ovr_wait", 10);
      check("ovr_id", 32'(irq_id), 32'd4);
      irq_in[4] = 1'b0;
      tick(3);
      irq_in[4] = 1'b1;
      ovr_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (irq_overrun[4]) ovr_cnt++;
      end
      check("ovr_pulses", 32'(ovr_cnt), 32'd1);
      $display("txn: set-wins ch4");
      irq_in[4] = 1'b0;
      tick(3);
      irq_in[4] = 1'b1;
      tick(2);
      do_ack();
      check("sw_pending", 32'(irq_pending[4]), 32'd1);
      check("sw_gap_req", 32'(irq_req),        32'd0);
      check("sw_no_ovr",  32'(irq_overrun[4]), 32'd0);
      wait_req("sw_rereq", 6);
      check("sw_rereq_id", 32'(irq_id), 32'd4);
      do_ack();
      check("sw_cleared", 32'(irq_pending[4]), 32'd0);
      irq_in = '0;
      tick(4);

      // ---- reset during request ----
      $display("txn: reset mid-request ch7");
      irq_in[7] = 1'b1;
      wait_req("rr_wait", 10);
      check("rr_id", 32'(irq_id), 32'd7);
      #2 reset_n = 1'b0;
      #1;
      check("rr_async_req", 32'(irq_req),     32'd0);
      check("rr_async_pnd", 32'(irq_pending), 32'd0);
      check("rr_async_id",  32'(irq_id),      32'd0);
      check("rr_async_ovr", 32'(irq_overrun), 32'd0);
      tick(2);
      #2 reset_n = 1'b1;
      tick(10);
      check("rr_held_noreq", 32'(irq_req),     32'd0);
      check("rr_held_nopnd", 32'(irq_pending), 32'd0);
      irq_in[7] = 1'b0;
      tick(4);
      irq_in[7] = 1'b1;
      wait_req("rr_new_edge", 10);
      check("rr_new_id", 32'(irq_id), 32'd7);
      do_ack();
      irq_in = '0;
      tick(4);

`ifdef IRQ_LEVEL_MODE_EN
      // ---- level-mode channel 6 ----
      $display("txn: level ch6");
      irq_level[6] = 1'b1; irq_in[6] = 1'b1;
      for (int r = 0; r < 3; r++) begin
         wait_req("lvl_wait", 10);
         check("lvl_id", 32'(irq_id), 32'd6);
         if (r == 2) begin
            irq_in[6] = 1'b0;
            tick(5);
            check("lvl_drop_pnd", 32'(irq_pending[6]), 32'd0);
         end
         do_ack();
         check("lvl_gap", 32'(irq_req), 32'd0);
      end
      tick(10);
      check("lvl_no_more", 32'(irq_req), 32'd0);
      irq_level = '0;
      tick(2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
